// File: rtl/bus_xfer_sequencer_pkg.sv
// Shared IDs, sizes, FSM state type and request record for the bus transfer sequencer.
package bus_xfer_sequencer_pkg;

    localparam int NUM_SRC = 24;
    localparam int NUM_DST = 24;
    localparam int ID_W    = 5;

    localparam logic [ID_W-1:0] SRC_R0     = 5'd0;
    localparam logic [ID_W-1:0] SRC_HI     = 5'd16;
    localparam logic [ID_W-1:0] SRC_LO     = 5'd17;
    localparam logic [ID_W-1:0] SRC_ZHI    = 5'd18;
    localparam logic [ID_W-1:0] SRC_ZLO    = 5'd19;
    localparam logic [ID_W-1:0] SRC_PC     = 5'd20;
    localparam logic [ID_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [ID_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [ID_W-1:0] SRC_C      = 5'd23;

    localparam logic [ID_W-1:0] DST_R0      = 5'd0;
    localparam logic [ID_W-1:0] DST_HI      = 5'd16;
    localparam logic [ID_W-1:0] DST_LO      = 5'd17;
    localparam logic [ID_W-1:0] DST_PC      = 5'd18;
    localparam logic [ID_W-1:0] DST_MDR     = 5'd19;
    localparam logic [ID_W-1:0] DST_MAR     = 5'd20;
    localparam logic [ID_W-1:0] DST_IR      = 5'd21;
    localparam logic [ID_W-1:0] DST_Y       = 5'd22;
    localparam logic [ID_W-1:0] DST_OUTPORT = 5'd23;

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ERR} xfer_state_e;

    typedef struct packed {
        logic [ID_W-1:0] src;
        logic [ID_W-1:0] dst;
    } xfer_req_t;

    function automatic logic req_ok(xfer_req_t r);
        return (r.src <= SRC_C) && (r.dst <= DST_OUTPORT);
    endfunction

    function automatic logic [NUM_SRC-1:0] src_onehot(logic [ID_W-1:0] id);
        return NUM_SRC'(1) << id;
    endfunction

    function automatic logic [NUM_DST-1:0] dst_onehot(logic [ID_W-1:0] id);
        return NUM_DST'(1) << id;
    endfunction

endpackage

// File: rtl/bus_xfer_sequencer_if.sv
// Request handshake and bus enable bundle between a requester and the sequencer.
interface bus_xfer_sequencer_if;
    import bus_xfer_sequencer_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [ID_W-1:0]    req_src;
    logic [ID_W-1:0]    req_dst;
    logic [NUM_SRC-1:0] out_en;
    logic [NUM_DST-1:0] in_en;
    logic               done;
    logic               err;
    logic               busy;

    modport master (
        output req_valid, req_src, req_dst,
        input  req_ready, out_en, in_en, done, err, busy
    );

    modport slave (
        input  req_valid, req_src, req_dst,
        output req_ready, out_en, in_en, done, err, busy
    );

endinterface

// File: rtl/bus_xfer_sequencer_fifo.sv
// Two-entry request queue; 1-bit pointers wrap naturally, count tracks occupancy 0..2.
module xfer_req_fifo
    import bus_xfer_sequencer_pkg::*;
(
    input  logic      clock,
    input  logic      clear,
    input  logic      push,
    input  logic      pop,
    input  xfer_req_t wdata,
    output xfer_req_t rdata,
    output logic [1:0] count
);

    xfer_req_t  mem_q [2];
    xfer_req_t  mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok, pop_ok;

    assign push_ok = push && (count_q != 2'd2);
    assign pop_ok  = pop && (count_q != 2'd0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) rd_ptr_d = ~rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Sequences queued register transfers into a drive cycle then a load cycle on the shared bus.
//   state | meaning
//   IDLE  | nothing in flight; pop head as soon as the queue is non-empty
//   DRIVE | source enable on, destination enables off
//   LOAD  | source enable held, destination load pulsed, done pulsed
//   ERR   | invalid request discarded, err pulsed, all enables off
module bus_xfer_sequencer
    import bus_xfer_sequencer_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    bus_xfer_sequencer_if.slave  bus
);

    xfer_state_e        state_q, state_d;
    logic [ID_W-1:0]    dst_q, dst_d;
    logic [NUM_SRC-1:0] out_en_q, out_en_d;
    logic [NUM_DST-1:0] in_en_q, in_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;

    logic       push, pop;
    logic [1:0] fifo_count, count_next;
    xfer_req_t  req_in, head;

    assign req_in = '{src: bus.req_src, dst: bus.req_dst};
    assign push   = bus.req_valid && ready_q;

    xfer_req_fifo u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (req_in),
        .rdata (head),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = IDLE;
        dst_d    = dst_q;
        out_en_d = '0;
        in_en_d  = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        pop      = 1'b0;
        case (state_q)
            DRIVE: begin
                state_d  = LOAD;
                out_en_d = out_en_q;
                in_en_d  = dst_onehot(dst_q);
                done_d   = 1'b1;
            end
            // IDLE, LOAD and ERR all dispatch the next head the same way
            default: begin
                if (fifo_count != 2'd0) begin
                    pop   = 1'b1;
                    dst_d = head.dst;
                    if (req_ok(head)) begin
                        state_d  = DRIVE;
                        out_en_d = src_onehot(head.src);
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
        endcase
        count_next = fifo_count + 2'(push) - 2'(pop);
        ready_d    = (count_next != 2'd2);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= IDLE;
            dst_q    <= '0;
            out_en_q <= '0;
            in_en_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            out_en_q <= out_en_d;
            in_en_q  <= in_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.out_en    = out_en_q;
    assign bus.in_en     = in_en_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != IDLE) || (fifo_count != 2'd0);

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: schedule-based reference model, directed scenarios and random traffic.
module tb_bus_xfer_sequencer;
    import bus_xfer_sequencer_pkg::*;

    localparam int N = 4096;

    logic clock = 1'b0;
    logic clear = 1'b0;

    bus_xfer_sequencer_if bus();

    bus_xfer_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int ncmp = 0;
    int nerr = 0;

    // expected value after edge k is stored at index k
    logic [23:0] exp_out [N];
    logic [23:0] exp_in  [N];
    bit          exp_done[N];
    bit          exp_err [N];
    bit          exp_ready[N];
    bit          exp_busy[N];
    bit          slot    [N];
    int          pop_at  [N];

    logic [23:0] obs_out [N];
    logic [23:0] obs_in  [N];
    bit          obs_done[N];
    bit          obs_err [N];
    bit          obs_ready[N];
    bit          obs_busy[N];

    int acc_sum    = 0;
    int popped_sum = 0;
    int next_free  = 0;
    int last_acc   = 0;
    int step_k     = -1;
    bit model_rst  = 1'b1;
    bit chk_en     = 1'b0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic wipe_model(input int from);
        for (int i = from; i < from + 16 && i < N; i++) begin
            exp_out[i] = '0; exp_in[i] = '0; exp_done[i] = 0; exp_err[i] = 0;
            exp_ready[i] = 0; exp_busy[i] = 0; slot[i] = 0; pop_at[i] = 0;
        end
    endtask

    // A request accepted on edge a starts on the later of edge a+1 and the first free slot;
    // valid requests take two slots (drive, load), invalid ones take one (err).
    task automatic accept_req(input int a, input logic [4:0] s, input logic [4:0] d);
        int st;
        st = (next_free > a + 1) ? next_free : a + 1;
        acc_sum++;
        pop_at[st]++;
        slot[st] = 1;
        if (s < 24 && d < 24) begin
            exp_out[st]     = 24'h1 << s;
            exp_out[st + 1] = 24'h1 << s;
            exp_in[st + 1]  = 24'h1 << d;
            exp_done[st + 1] = 1;
            slot[st + 1]    = 1;
            next_free       = st + 2;
        end else begin
            exp_err[st] = 1;
            next_free   = st + 1;
        end
        last_acc = a;
    endtask

    // rst_op: 0 none, 1 assert clear, 2 release clear
    task automatic step(input bit v, input logic [4:0] s, input logic [4:0] d, input int rst_op);
        int k;
        int cnt;
        @(posedge clock);
        #2;
        k = cyc;
        if (rst_op == 1) begin
            clear      = 1'b0;
            model_rst  = 1'b1;
            acc_sum    = 0;
            popped_sum = 0;
            next_free  = 0;
            wipe_model(k);
        end
        popped_sum += pop_at[k];
        cnt = acc_sum - popped_sum;
        exp_ready[k] = !model_rst && (cnt != 2);
        exp_busy[k]  = slot[k] || (cnt != 0);
        if (rst_op == 2) begin
            clear     = 1'b1;
            model_rst = 1'b0;
        end
        bus.req_valid = v;
        bus.req_src   = s;
        bus.req_dst   = d;
        if (v && exp_ready[k] && clear) accept_req(k + 1, s, d);
        step_k = k;
        chk_en = 1'b1;
    endtask

    always @(negedge clock) begin
        if (chk_en && step_k == cyc) begin
            obs_out[cyc]   <= bus.out_en;
            obs_in[cyc]    <= bus.in_en;
            obs_done[cyc]  <= bus.done;
            obs_err[cyc]   <= bus.err;
            obs_ready[cyc] <= bus.req_ready;
            obs_busy[cyc]  <= bus.busy;
            ncmp++;
            assert ($onehot0(bus.out_en) && $onehot0(bus.in_en) && !(bus.in_en != 0 && bus.out_en == 0))
            else begin
                nerr++;
                $display("FAIL enable_onehot cycle %0d: out_en 0x%0h in_en 0x%0h", cyc, bus.out_en, bus.in_en);
            end
            if (!clear) begin
                chk("rst_out_en", cyc, 32'(bus.out_en), 32'h0);
                chk("rst_in_en", cyc, 32'(bus.in_en), 32'h0);
                chk("rst_done", cyc, 32'(bus.done), 32'h0);
                chk("rst_err", cyc, 32'(bus.err), 32'h0);
                chk("rst_busy", cyc, 32'(bus.busy), 32'h0);
                chk("rst_ready", cyc, 32'(bus.req_ready), 32'h0);
            end else begin
                chk("out_en", cyc, 32'(bus.out_en), 32'(exp_out[cyc]));
                chk("in_en", cyc, 32'(bus.in_en), 32'(exp_in[cyc]));
                chk("done", cyc, 32'(bus.done), 32'(exp_done[cyc]));
                chk("err", cyc, 32'(bus.err), 32'(exp_err[cyc]));
                chk("busy", cyc, 32'(bus.busy), 32'(exp_busy[cyc]));
                chk("req_ready", cyc, 32'(bus.req_ready), 32'(exp_ready[cyc]));
            end
        end
    end

    initial begin
        int r0, a, t, e, m;
        logic [7:0] mk;
        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        wipe_model(0);

        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 2);
        r0 = step_k;
        repeat (2) step(0, 0, 0, 0);
        chk("ready_held_low_release", r0, 32'(obs_ready[r0]), 32'h0);
        chk("ready_first_edge", r0 + 1, 32'(obs_ready[r0 + 1]), 32'h1);

        // PC -> MAR
        step(1, 5'd20, 5'd20, 0);
        a = last_acc;
        repeat (5) step(0, 0, 0, 0);
        chk("pc_mar_drive_out", a + 1, 32'(obs_out[a + 1]), 32'h100000);
        chk("pc_mar_drive_in", a + 1, 32'(obs_in[a + 1]), 32'h0);
        chk("pc_mar_load_out", a + 2, 32'(obs_out[a + 2]), 32'h100000);
        chk("pc_mar_load_in", a + 2, 32'(obs_in[a + 2]), 32'h100000);
        chk("pc_mar_done", a + 2, 32'(obs_done[a + 2]), 32'h1);

        // back-to-back with valid held
        step(1, 5'd3, 5'd5, 0);
        t = last_acc;
        step(1, 5'd21, 5'd21, 0);
        step(1, 5'd16, 5'd0, 0);
        repeat (9) step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) mk[i] = obs_done[t + i];
        chk("b2b_done_slots", t, 32'(mk), 32'h54);
        chk("b2b_out_1", t + 1, 32'(obs_out[t + 1]), 32'h8);
        chk("b2b_in_1", t + 2, 32'(obs_in[t + 2]), 32'h20);
        chk("b2b_out_2", t + 3, 32'(obs_out[t + 3]), 32'h200000);
        chk("b2b_out_3", t + 5, 32'(obs_out[t + 5]), 32'h10000);
        chk("b2b_in_3", t + 6, 32'(obs_in[t + 6]), 32'h1);
        chk("b2b_ready_open", t + 1, 32'(obs_ready[t + 1]), 32'h1);
        chk("b2b_ready_full", t + 2, 32'(obs_ready[t + 2]), 32'h0);

        // invalid source then a normal transfer
        step(1, 5'd27, 5'd4, 0);
        e = last_acc;
        step(1, 5'd1, 5'd2, 0);
        repeat (5) step(0, 0, 0, 0);
        chk("inv_err", e + 1, 32'(obs_err[e + 1]), 32'h1);
        chk("inv_out", e + 1, 32'(obs_out[e + 1]), 32'h0);
        chk("inv_in", e + 1, 32'(obs_in[e + 1]), 32'h0);
        chk("inv_next_drive", e + 2, 32'(obs_out[e + 2]), 32'h2);
        chk("inv_next_done", e + 3, 32'(obs_done[e + 3]), 32'h1);
        chk("inv_next_in", e + 3, 32'(obs_in[e + 3]), 32'h4);

        // reset during LOAD of 7->9 with 4->4 queued behind it
        step(1, 5'd7, 5'd9, 0);
        m = last_acc;
        step(1, 5'd4, 5'd4, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 2);
        repeat (7) step(0, 0, 0, 0);
        chk("abort_drive_seen", m + 1, 32'(obs_out[m + 1]), 32'h80);
        chk("abort_done", m + 2, 32'(obs_done[m + 2]), 32'h0);
        chk("abort_in", m + 2, 32'(obs_in[m + 2]), 32'h0);
        chk("abort_out", m + 2, 32'(obs_out[m + 2]), 32'h0);
        for (int i = 0; i < 8; i++) mk[i] = obs_done[m + 2 + i];
        chk("abort_no_done_after", m + 2, 32'(mk), 32'h0);
        chk("abort_busy", m + 6, 32'(obs_busy[m + 6]), 32'h0);
        chk("abort_ready", m + 6, 32'(obs_ready[m + 6]), 32'h1);

        // random traffic with one reset in the middle
        for (int i = 0; i < 500; i++) begin
            bit v;
            logic [4:0] s, d;
            int ro;
            v = ((i % 100) < 30) ? 1'b1 : ($urandom_range(0, 9) < 6);
            s = ($urandom_range(0, 99) < 10) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            d = ($urandom_range(0, 99) < 10) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            ro = 0;
            if (i == 250) ro = 1;
            if (i == 252) ro = 2;
            if (ro != 0) v = 1'b0;
            step(v, s, d, ro);
        end
        repeat (8) step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/bus_xfer_sequencer.md
BUS_XFER_SEQUENCER -- requirements
Module: bus_xfer_sequencer

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Port `clock`, input, 1 bit: single rising-edge clock.
REQ-003 Port `clear`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `req_valid`, input, 1 bit: transfer request present.
REQ-005 Port `req_ready`, output, 1 bit: request queue can accept a request.
REQ-006 Port `req_src`, input, 5 bits: source ID.
  - 0-15 = R0-R15
  - 16 = HI, 17 = LO, 18 = ZHI, 19 = ZLO, 20 = PC, 21 = MDR, 22 = INPORT, 23 = C
REQ-007 Port `req_dst`, input, 5 bits: destination ID.
  - 0-15 = R0-R15
  - 16 = HI, 17 = LO, 18 = PC, 19 = MDR, 20 = MAR, 21 = IR, 22 = Y, 23 = OUTPORT
REQ-008 Port `out_en`, output, 24 bits: one-hot source drive enables, bit n = source ID n; feeds the bus multiplexer enables.
REQ-009 Port `in_en`, output, 24 bits: one-hot destination load enables, bit n = destination ID n.
REQ-010 Port `done`, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-011 Port `err`, output, 1 bit: one-cycle pulse when a request is discarded as invalid.
REQ-012 Port `busy`, output, 1 bit: high when the FSM is not IDLE or the queue is non-empty.

Function
REQ-013 A request SHALL be accepted on any rising edge where `req_valid` and `req_ready` are both 1.
REQ-014 Accepted requests SHALL enter a 2-entry FIFO.
  - `req_ready` = 0 only when the FIFO holds 2 entries.
  - Requests are served in acceptance order.
REQ-015 The FSM SHALL have the states IDLE, DRIVE, LOAD and ERR.
REQ-016 IDLE SHALL pop the FIFO head when the FIFO is non-empty.
  - Next state is DRIVE if src <= 23 and dst <= 23.
  - Otherwise next state is ERR.
REQ-017 DRIVE SHALL last exactly 1 cycle.
  - `out_en[src]` = 1; all other `out_en` bits = 0; `in_en` = 0.
  - Next state is LOAD.
REQ-018 LOAD SHALL last exactly 1 cycle.
  - `out_en[src]` held at 1; `in_en[dst]` = 1; `done` = 1.
  - Next state is DRIVE on the new head if the FIFO is non-empty and the head is valid; ERR if non-empty and the head is invalid; IDLE if empty.
REQ-019 ERR SHALL last exactly 1 cycle.
  - `err` = 1; `out_en` = 0; `in_en` = 0.
  - Next state follows the same rule as LOAD.
REQ-020 Timing SHALL be as follows.
  - Latency from the accept edge to the first DRIVE cycle is 1 cycle when the FIFO is empty and the FSM is IDLE.
  - Sustained throughput is 1 transfer per 2 cycles.
REQ-021 `out_en` and `in_en` SHALL be registered outputs, never more than one bit set each, and glitch-free.
REQ-022 `src` == `dst` numerically SHALL be legal, since the ID spaces are independent.
REQ-023 When a push and a pop occur on the same edge with the FIFO full, the push SHALL be refused because `req_ready` = 0 that cycle.
  - With the FIFO at 1 entry, a simultaneous push and pop SHALL leave the count at 1.
REQ-024 The FIFO read and write pointers SHALL be 1 bit each and wrap modulo 2.
  - The count SHALL be 2 bits wide (0-2).

Reset
REQ-025 While `clear` = 0, the block SHALL hold the following values asynchronously:
  - FSM in IDLE; FIFO empty with pointers at 0.
  - `out_en` = 0, `in_en` = 0, `done` = 0, `err` = 0, `busy` = 0, `req_ready` = 0.
REQ-026 `req_ready` SHALL rise on the first rising edge after `clear` deasserts.
REQ-027 Reset during DRIVE or LOAD SHALL abort the transfer with no `done` pulse, and queued requests SHALL be lost.

Structure
REQ-028 A shared package SHALL hold the following:
  - Source-ID and destination-ID constants.
  - `NUM_SRC` = 24, `NUM_DST` = 24.
  - The FSM state enum {IDLE, DRIVE, LOAD, ERR}.
REQ-029 The 2-entry request FIFO SHALL be a sub-module named `xfer_req_fifo`, 10 bits wide (src, dst).
REQ-030 The one-hot decode SHALL be inline, with no separate decoder module.

Verification
REQ-031 Single transfer: src = 20 (PC), dst = 20 (MAR).
  - DRIVE cycle: `out_en` = 0x100000, `in_en` = 0.
  - Next cycle: `out_en` = 0x100000, `in_en` = 0x100000, `done` = 1.
REQ-032 Back-to-back requests (3->5, 21->21, 16->0) with `req_valid` held high.
  - `req_ready` drops after 2 accepts.
  - Exactly 3 `done` pulses on cycles t+2, t+4, t+6.
  - `out_en` sequence 0x8, 0x200000, 0x10000.
REQ-033 Invalid request: src = 27, dst = 4, followed by 1->2.
  - `err` pulse with `out_en` = `in_en` = 0.
  - Then a normal 1->2 transfer, with `done` 2 cycles after ERR.
REQ-034 Reset mid-transfer: `clear` = 0 during LOAD of 7->9.
  - Same cycle: `in_en` = 0, `out_en` = 0, `done` = 0.
  - After release: `busy` = 0 and the FIFO is empty.
REQ-035 Throughout all tests, an assertion checks that `out_en` and `in_en` are each one-hot-or-zero every cycle, and that `in_en` is never non-zero while `out_en` is zero.
